obi_sram_arbiter: RTL

- Shares one single-port OBI SRAM slave among NUM_REQ OBI masters, e.g. GPGPU core instruction/data ports and a host loader.
- Round-robin arbitration with at most one transaction outstanding.
- Holds the request stable until the slave grants it.
- Routes the slave response back to the master that issued it.

---
 rtl/gpgpu_mem_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 28 ++
 rtl/obi_sram_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/gpgpu_mem_arb_pkg.sv
// Shared types for the OBI SRAM arbiter: FSM state encoding and owner-index width helper.
package gpgpu_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Width of a master index; never below one bit so single-bit ports stay legal.
    function automatic int owner_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate down so the nearest one to ptr is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/obi_sram_arbiter.sv
// Round-robin arbiter sharing one OBI SRAM slave among NUM_REQ masters, one transaction in flight.
// Handshake: a request transfers on req && gnt in the same cycle; its response is the next rvalid.
module obi_sram_arbiter
    import gpgpu_mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            m_req_i,
    input  logic [NUM_REQ-1:0]            m_we_i,
    input  logic [NUM_REQ*DATA_W/8-1:0]   m_be_i,
    input  logic [NUM_REQ*ADDR_W-1:0]     m_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]     m_wdata_i,
    output logic [NUM_REQ-1:0]            m_gnt_o,
    output logic [NUM_REQ-1:0]            m_rvalid_o,
    output logic [DATA_W-1:0]             m_rdata_o,
    output logic                          s_req_o,
    output logic                          s_we_o,
    output logic [DATA_W/8-1:0]           s_be_o,
    output logic [ADDR_W-1:0]             s_addr_o,
    output logic [DATA_W-1:0]             s_wdata_o,
    input  logic                          s_gnt_i,
    input  logic                          s_rvalid_i,
    input  logic [DATA_W-1:0]             s_rdata_i,
    output logic [owner_w(NUM_REQ)-1:0]   owner_o,
    output logic                          busy_o,
    output logic                          stray_rsp_o,
    output logic [1:0]                    state_o
);

    localparam int BE_W    = DATA_W / 8;
    localparam int OWNER_W = owner_w(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [OWNER_W-1:0] sel;
    logic               drive;
    logic               stray_q;
    logic               pick_valid;
    logic [OWNER_W-1:0] pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWNER_W)
    ) u_rr_pick (
        .req   (m_req_i),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        sel        = owner_q;
        drive      = 1'b0;
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    sel     = pick_idx;
                    drive   = 1'b1;
                    owner_d = pick_idx;
                    state_d = s_gnt_i ? RESP : HOLD;
                end
            end
            HOLD: begin
                // A master withdrawing an ungranted request is abandoned, not forwarded.
                if (m_req_i[owner_q]) begin
                    drive   = 1'b1;
                    state_d = s_gnt_i ? RESP : HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (s_rvalid_i) begin
                    m_rvalid_o[owner_q] = 1'b1;
                    m_rdata_o           = s_rdata_i;
                    state_d             = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (drive && s_gnt_i) begin
            m_gnt_o[sel] = 1'b1;
            rr_ptr_d     = (sel == OWNER_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
        end

        s_req_o   = drive;
        s_we_o    = drive & m_we_i[sel];
        s_be_o    = drive ? m_be_i[sel*BE_W +: BE_W] : '0;
        s_addr_o  = drive ? m_addr_i[sel*ADDR_W +: ADDR_W] : '0;
        s_wdata_o = drive ? m_wdata_i[sel*DATA_W +: DATA_W] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            stray_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            // A response with nothing outstanding is dropped but remembered until reset.
            if (s_rvalid_i && (state_q != RESP)) begin
                stray_q <= 1'b1;
            end
        end
    end

    assign owner_o     = owner_q;
    assign busy_o      = (state_q != IDLE);
    assign stray_rsp_o = stray_q;
    assign state_o     = state_q;

endmodule
